// File: rtl/sram_pkg.sv
// Shared types for the SRAM arbiter slice:
// requester roles and the latched request bundle.
package sram_pkg;
  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    PORT_VGA   = 2'd0,
    PORT_GAME  = 2'd1,
    PORT_AUDIO = 2'd2
  } sram_port_e;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/sram_rr_picker.sv
// Round-robin choice between the game and audio ports,
// with starved requests taking precedence over fresh ones.
module sram_rr_picker
  import sram_pkg::*;
#(
  parameter int STARVE_LIMIT = 64,
  parameter int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic [1:0]         i_req,
  input  logic [1:0][SW-1:0] i_cnt,
  input  logic               i_ptr,
  output sram_port_e         o_sel,
  output logic               o_any,
  output logic               o_preempt
);
  logic [1:0] starve;
  logic [1:0] cand;
  logic       pick_hi;

  always_comb begin
    for (int i = 0; i < 2; i++)
      starve[i] = i_req[i]
        && (i_cnt[i] >= SW'(STARVE_LIMIT));
    o_any     = |i_req;
    o_preempt = |starve;
    cand      = o_preempt ? starve : i_req;
    // A tie between the two goes to the pointer.
    pick_hi   = cand[1] && (!cand[0] || i_ptr);
    o_sel     = pick_hi ? PORT_AUDIO : PORT_GAME;
  end
endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter in front of the async SRAM:
// VGA first, starvation guard, game/audio round-robin.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 64,
  parameter int NUM_PORTS     = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_we,
  input  logic [NUM_PORTS-1:0][SRAM_ADDR_W-1:0] i_addr,
  input  logic [NUM_PORTS-1:0][SRAM_DATA_W-1:0] i_wdata,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [NUM_PORTS-1:0] o_rvalid,
  output logic [SRAM_DATA_W-1:0] o_rdata,
  output logic o_busy,
  output logic [SRAM_ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] io_SRAM_DQ,
  output logic o_SRAM_WE_N
);
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAST =
    CW'(ACCESS_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  sram_req_t              req_q, req_d;
  sram_port_e             win_q, win_d;
  logic                   ptr_q, ptr_d;
  logic [1:0][SW-1:0]     starve_q, starve_d;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;

  logic [NUM_PORTS-1:0] gnt;
  sram_port_e           sel, win;
  logic                 any12, preempt;
  logic                 last, drive;

  sram_rr_picker #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .SW(SW)
  ) u_pick (
    .i_req    (i_req[2:1]),
    .i_cnt    (starve_q),
    .i_ptr    (ptr_q),
    .o_sel    (sel),
    .o_any    (any12),
    .o_preempt(preempt)
  );

  assign last  = (cnt_q == LAST);
  assign drive = (state_q == ACCESS) && req_q.we;

  always_comb begin
    win = (preempt || !i_req[0]) ? sel : PORT_VGA;
    gnt = '0;
    if (state_q == IDLE && i_rst_n
        && (i_req[0] || any12))
      gnt[win] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    unique case (state_q)
      IDLE: if (|gnt) begin
        state_d = ACCESS;
        cnt_d   = '0;
        win_d   = win;
        req_d   = '{we:    i_we[win],
                    addr:  i_addr[win],
                    wdata: i_wdata[win]};
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = IDLE;
          if (!req_q.we) begin
            rdata_d         = io_SRAM_DQ;
            rvalid_d[win_q] = 1'b1;
          end
        end
      end
    endcase
    if (gnt[1]) ptr_d = 1'b1;
    if (gnt[2]) ptr_d = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (!i_req[i+1] || gnt[i+1])
        starve_d[i] = '0;
      else if (starve_q[i] < SW'(STARVE_LIMIT))
        starve_d[i] = starve_q[i] + 1'b1;
      else
        starve_d[i] = starve_q[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      win_q    <= PORT_VGA;
      ptr_q    <= 1'b0;
      starve_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Strobe is released on the last cycle for data hold.
  assign o_SRAM_WE_N = !(drive && !last);
  assign io_SRAM_DQ  = drive ? req_q.wdata : 'z;
  assign o_SRAM_ADDR = req_q.addr;
  assign o_busy      = (state_q == ACCESS);
  assign o_gnt       = gnt;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (2- and 4-cycle
// access) sharing stimulus, each with its own SRAM model.
module tb_sram_arbiter;
  localparam int LIM = 64;
  localparam int AC0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] req, we;
  logic [2:0][19:0] addr;
  logic [2:0][15:0] wdata;

  logic [2:0]  gnt    [2];
  logic [2:0]  rvalid [2];
  logic [15:0] rdata  [2];
  logic        busy   [2];
  logic [19:0] saddr  [2];
  logic        we_n   [2];
  wire  [15:0] dq_mon [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] mem [1024];
    logic        cur_wr;
    wire  [15:0] dq;

    sram_arbiter #(
      .ACCESS_CYCLES((g == 0) ? 2 : 4),
      .STARVE_LIMIT(LIM),
      .NUM_PORTS(3)
    ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req(req), .i_we(we),
      .i_addr(addr), .i_wdata(wdata),
      .o_gnt(gnt[g]), .o_rvalid(rvalid[g]),
      .o_rdata(rdata[g]), .o_busy(busy[g]),
      .o_SRAM_ADDR(saddr[g]), .io_SRAM_DQ(dq),
      .o_SRAM_WE_N(we_n[g])
    );

    assign dq = (busy[g] && we_n[g] && !cur_wr)
      ? mem[saddr[g][9:0]] : 16'hzzzz;
    assign dq_mon[g] = dq;

    initial begin
      cur_wr = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
      if (|gnt[g]) cur_wr <= |(gnt[g] & we);
      if (!we_n[g]) mem[saddr[g][9:0]] <= dq;
    end
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
  } vec_t;

  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
  } rd_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    we = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wr_rd(input int g, input int ac);
    int lo = 0;
    do_reset();
    req = 3'b010; we = 3'b010;
    addr[1] = 20'h00123; wdata[1] = 16'hBEEF;
    @(negedge clk);
    chk("wr_gnt", gnt[g], 3'b010);
    for (int k = 1; k <= ac; k++) begin
      tick();
      req = '0; we = '0;
      @(negedge clk);
      chk("wr_busy", busy[g], 1);
      chk("wr_dq", dq_mon[g], 16'hBEEF);
      chk("wr_addr", saddr[g], 20'h00123);
      if (!we_n[g]) lo++;
      if (k == ac) chk("wr_we_hold", we_n[g], 1);
    end
    chk("wr_we_low_cycles", lo, ac - 1);
    tick();
    @(negedge clk);
    chk("wr_idle", busy[g], 0);
    tick();
    req = 3'b010; we = '0;
    @(negedge clk);
    chk("rd_gnt", gnt[g], 3'b010);
    for (int k = 1; k <= ac + 1; k++) begin
      tick();
      req = '0;
      @(negedge clk);
      chk("rd_rvalid", rvalid[g],
          (k == ac + 1) ? 3'b010 : 3'b000);
      if (k == ac + 1)
        chk("rd_data", rdata[g], 16'hBEEF);
    end
  endtask

  task automatic contention();
    int f1 = -1, f2 = -1, n0 = 0;
    logic [2:0] g;
    do_reset();
    req = 3'b111; we = '0;
    addr = {20'h3, 20'h2, 20'h1};
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      g = gnt[0];
      if (g[1] && f1 < 0) f1 = c;
      if (g[2] && f2 < 0) f2 = c;
      if (g[0]) n0++;
      tick();
      if (g[1]) req[1] = 1'b0;
      if (g[2]) req[2] = 1'b0;
    end
    chk("starve_p1_cycle", f1, 66);
    chk("starve_p2_cycle", f2, 69);
    chk("starve_p0_grants", n0, 28);
  endtask

  task automatic round_robin();
    logic [2:0] e;
    do_reset();
    req = 3'b110; we = '0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      e = '0;
      if (c % 3 == 0)
        e = ((c / 3) % 2 == 0) ? 3'b010 : 3'b100;
      chk("rr_gnt", gnt[0], e);
      tick();
    end
    req = '0;
  endtask

  task automatic reset_mid_write();
    do_reset();
    req = 3'b001; we = 3'b001;
    addr[0] = 20'h00055; wdata[0] = 16'h1234;
    @(negedge clk);
    chk("rstw_gnt", gnt[0], 3'b001);
    tick();
    req = '0; we = '0;
    chk("rstw_we_low", we_n[0], 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_we_n", we_n[0], 1);
    chk("rstw_busy", busy[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstw_no_rvalid", rvalid[0], 3'b000);
      chk("rstw_idle", busy[0], 0);
      tick();
    end
    req = 3'b010; addr[1] = 20'h00055;
    @(negedge clk);
    chk("rstw_regnt", gnt[0], 3'b010);
    for (int k = 1; k <= 3; k++) begin
      tick();
      req = '0;
      @(negedge clk);
      chk("rstw_rd_rvalid", rvalid[0],
          (k == 3) ? 3'b010 : 3'b000);
    end
  endtask

  task automatic withdrawn();
    do_reset();
    req = 3'b001; we = '0; addr[0] = 20'h7;
    @(negedge clk);
    chk("wd_gnt0", gnt[0], 3'b001);
    tick();
    req = 3'b100; addr[2] = 20'h9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wd_no_gnt", gnt[0], 3'b000);
      tick();
    end
    req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wd_after", gnt[0], 3'b000);
      tick();
    end
  endtask

  // Model: one grant per AC0+1 cycles, rules on wait counts.
  task automatic run_random();
    int w1 = 0, w2 = 0, rr = 1, nfree = 0;
    int win, pr0, pr;
    logic s1, s2;
    logic [2:0] lastg = '0;
    logic [2:0] expg, exprv;
    logic [15:0] refmem [16];
    rd_t q[$];
    for (int i = 0; i < 16; i++) refmem[i] = '0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      pr0 = (c < 1000) ? 30 : (c < 2000) ? 90 :
            (c < 3000) ? 0 : 60;
      for (int p = 0; p < 3; p++) begin
        pr = (p == 0) ? pr0 : 40;
        if (req[p] && lastg[p])
          req[p] = 1'b0;
        else if (req[p] && p != 0
                 && $urandom_range(199) == 0)
          req[p] = 1'b0;
        else if (!req[p]
                 && int'($urandom_range(99)) < pr) begin
          req[p] = 1'b1;
          we[p] = 1'($urandom_range(1));
          addr[p] = 20'h200 + 20'($urandom_range(15));
          wdata[p] = 16'($urandom);
        end
      end
      @(negedge clk);
      expg = '0;
      if (c >= nfree && |req) begin
        s1 = req[1] && w1 >= LIM;
        s2 = req[2] && w2 >= LIM;
        if (s1 || s2)
          win = (s1 && s2) ? rr : (s1 ? 1 : 2);
        else if (req[0])
          win = 0;
        else
          win = (req[1] && req[2]) ? rr
              : (req[1] ? 1 : 2);
        expg[win] = 1'b1;
        nfree = c + AC0 + 1;
        if (we[win])
          refmem[addr[win][3:0]] = wdata[win];
        else
          q.push_back('{c + AC0 + 1, win,
                        refmem[addr[win][3:0]]});
        if (win != 0) rr = (win == 1) ? 2 : 1;
      end
      chk("rnd_gnt", gnt[0], expg);
      exprv = '0;
      if (q.size() > 0 && q[0].due == c) begin
        exprv[q[0].port] = 1'b1;
        chk("rnd_rdata", rdata[0], q[0].data);
        void'(q.pop_front());
      end
      chk("rnd_rvalid", rvalid[0], exprv);
      w1 = (!req[1] || expg[1]) ? 0
         : ((w1 < LIM) ? w1 + 1 : w1);
      w2 = (!req[2] || expg[2]) ? 0
         : ((w2 < LIM) ? w2 + 1 : w2);
      lastg = gnt[0];
      tick();
    end
    req = '0;
  endtask

  initial begin
    vec_t tbl [8];
    req = '0; we = '0; addr = '0; wdata = '0;
    @(negedge clk);
    chk("rst_gnt", gnt[0], 3'b000);
    chk("rst_rvalid", rvalid[0], 3'b000);
    chk("rst_rdata", rdata[0], 16'h0);
    chk("rst_busy", busy[0], 0);
    chk("rst_addr", saddr[0], 20'h0);
    chk("rst_we_n", we_n[0], 1);

    tbl[0] = '{3'b000, 3'b000};
    tbl[1] = '{3'b001, 3'b001};
    tbl[2] = '{3'b010, 3'b010};
    tbl[3] = '{3'b100, 3'b100};
    tbl[4] = '{3'b110, 3'b010};
    tbl[5] = '{3'b111, 3'b001};
    tbl[6] = '{3'b101, 3'b001};
    tbl[7] = '{3'b011, 3'b001};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      req = tbl[i].req;
      @(negedge clk);
      chk("tbl_gnt", gnt[0], tbl[i].gnt);
      chk("tbl_gnt_ac4", gnt[1], tbl[i].gnt);
      tick();
      req = '0;
      @(negedge clk);
      chk("tbl_busy", busy[0], |tbl[i].gnt);
    end

    wr_rd(0, 2);
    wr_rd(1, 4);
    contention();
    round_robin();
    reset_mid_write();
    withdrawn();
    run_random();

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
